// File: rtl/spike_scheduler.sv
// spike_scheduler: holds soma fire pulses for a per-neuron axon delay (in ticks),
// then releases matured spikes one per cycle onto an AER bus with round-robin arbitration.
// Ports: clk/rst (async active-low), tick (timestep strobe), fire[N] (soma pulses),
//   cfg_we/cfg_addr/cfg_delay/cfg_en (per-neuron delay+enable write),
//   aer_valid/aer_ready/aer_addr/aer_time (event output handshake), drop_cnt (saturating).
// Optional: define SPIKE_SCHED_TIMESTAMP_EN to keep the timestep counter; otherwise aer_time is 0.
module spike_scheduler #(
  parameter int N_NEURON = 8,
  parameter int ADDR_W   = 3,
  parameter int DELAY_W  = 8,
  parameter int TIME_W   = 16,
  parameter int DROP_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [N_NEURON-1:0] fire,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [DELAY_W-1:0]  cfg_delay,
  input  logic                cfg_en,
  output logic                aer_valid,
  input  logic                aer_ready,
  output logic [ADDR_W-1:0]   aer_addr,
  output logic [TIME_W-1:0]   aer_time,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam int CNT_W = $clog2(N_NEURON + 1);
  localparam int SUM_W = DROP_W + CNT_W;

  logic [N_NEURON-1:0][DELAY_W-1:0] delay_q, delay_d;
  logic [N_NEURON-1:0][DELAY_W-1:0] cnt_q, cnt_d;
  logic [N_NEURON-1:0]              en_q, en_d;
  logic [N_NEURON-1:0]              busy_q, busy_d;
  logic [N_NEURON-1:0]              pend_q, pend_d;
  logic [ADDR_W-1:0]                ptr_q, ptr_d;
  logic                             aer_valid_q, aer_valid_d;
  logic [ADDR_W-1:0]                aer_addr_q, aer_addr_d;
  logic [TIME_W-1:0]                aer_time_q, aer_time_d;
  logic [DROP_W-1:0]                drop_q, drop_d;
  logic [TIME_W-1:0]                ts_q;

  logic              grant_vld;
  logic [ADDR_W-1:0] grant_idx;
  logic              load;
  logic              take;
  logic [CNT_W-1:0]  n_drop;
  logic [SUM_W-1:0]  drop_sum;

`ifdef SPIKE_SCHED_TIMESTAMP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_q <= '0;
    else if (tick) ts_q <= ts_q + TIME_W'(1);
  end
`else
  assign ts_q = '0;
`endif

  // Round-robin: first pending slot at or after the pointer, wrapping at N_NEURON-1.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_NEURON; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_NEURON) idx = idx - N_NEURON;
      if (!grant_vld && pend_q[idx]) begin
        grant_vld = 1'b1;
        grant_idx = ADDR_W'(idx);
      end
    end
  end

  assign load = !aer_valid_q || aer_ready;
  assign take = load && grant_vld;

  always_comb begin
    delay_d = delay_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    pend_d  = pend_q;
    n_drop  = '0;
    for (int i = 0; i < N_NEURON; i++) begin
      if (take && grant_idx == ADDR_W'(i)) pend_d[i] = 1'b0;
      if (busy_q[i] && tick) begin
        if (cnt_q[i] == DELAY_W'(1)) begin
          busy_d[i] = 1'b0;
          pend_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - DELAY_W'(1);
        end
      end
      // Flags are sampled as registered: a slot granted this cycle still counts as pending.
      if (fire[i] && en_q[i]) begin
        if (busy_q[i] || pend_q[i]) begin
          n_drop = n_drop + CNT_W'(1);
        end else begin
          cnt_d[i] = delay_q[i];
          if (delay_q[i] == '0) pend_d[i] = 1'b1;
          else                  busy_d[i] = 1'b1;
        end
      end
      // Disabling a neuron discards whatever it had in flight; cnt is left as loaded.
      if (cfg_we && cfg_addr == ADDR_W'(i)) begin
        delay_d[i] = cfg_delay;
        en_d[i]    = cfg_en;
        if (!cfg_en) begin
          busy_d[i] = 1'b0;
          pend_d[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    drop_sum = SUM_W'(drop_q) + SUM_W'(n_drop);
    if (|drop_sum[SUM_W-1:DROP_W]) drop_d = '1;
    else                           drop_d = drop_sum[DROP_W-1:0];
  end

  always_comb begin
    aer_valid_d = aer_valid_q;
    aer_addr_d  = aer_addr_q;
    aer_time_d  = aer_time_q;
    ptr_d       = ptr_q;
    if (load) begin
      aer_valid_d = grant_vld;
      if (grant_vld) begin
        aer_addr_d = grant_idx;
        aer_time_d = ts_q;
        ptr_d      = (grant_idx == ADDR_W'(N_NEURON - 1)) ? '0 : grant_idx + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      delay_q     <= '0;
      en_q        <= '1;
      cnt_q       <= '0;
      busy_q      <= '0;
      pend_q      <= '0;
      ptr_q       <= '0;
      aer_valid_q <= 1'b0;
      aer_addr_q  <= '0;
      aer_time_q  <= '0;
      drop_q      <= '0;
    end else begin
      delay_q     <= delay_d;
      en_q        <= en_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
      ptr_q       <= ptr_d;
      aer_valid_q <= aer_valid_d;
      aer_addr_q  <= aer_addr_d;
      aer_time_q  <= aer_time_d;
      drop_q      <= drop_d;
    end
  end

  assign aer_valid = aer_valid_q;
  assign aer_addr  = aer_addr_q;
  assign aer_time  = aer_time_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_spike_scheduler.sv
module tb_spike_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic [7:0]  fire = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [7:0]  cfg_delay = '0;
  logic        cfg_en = 1'b0;
  logic        aer_ready = 1'b0;
  logic        aer_valid;
  logic [2:0]  aer_addr;
  logic [15:0] aer_time;
  logic [7:0]  drop_cnt;
  // Second instance with a 2-bit drop counter, for saturation.
  logic        aer_valid2;
  logic [2:0]  aer_addr2;
  logic [15:0] aer_time2;
  logic [1:0]  drop_cnt2;

  spike_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .fire(fire),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_delay(cfg_delay), .cfg_en(cfg_en),
    .aer_valid(aer_valid), .aer_ready(aer_ready), .aer_addr(aer_addr),
    .aer_time(aer_time), .drop_cnt(drop_cnt)
  );

  spike_scheduler #(.DROP_W(2)) dut2 (
    .clk(clk), .rst(rst), .tick(tick), .fire(fire),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_delay(cfg_delay), .cfg_en(cfg_en),
    .aer_valid(aer_valid2), .aer_ready(aer_ready), .aer_addr(aer_addr2),
    .aer_time(aer_time2), .drop_cnt(drop_cnt2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int tm;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ts_model = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int exp_time();
`ifdef SPIKE_SCHED_TIMESTAMP_EN
    return ts_model;
`else
    return 0;
`endif
  endfunction

  task automatic push(input int addr, input int c);
    exp_t e;
    e.addr = addr;
    e.tm   = exp_time();
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every accepted event must match the head of the queue.
  always @(negedge clk) begin
    if (rst && aer_valid && aer_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got addr %0d at cycle %0d, expected no event", aer_addr, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("aer_addr", int'(aer_addr), e.addr);
        check("aer_time", int'(aer_time), e.tm);
        if (e.cyc >= 0) check("aer_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int addr, input int dly, input logic en);
    cfg_we = 1'b1; cfg_addr = 3'(addr); cfg_delay = 8'(dly); cfg_en = en;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic pulse_fire(input logic [7:0] m);
    fire = m;
    step(1);
    fire = '0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    ts_model++;
    step(1);
    tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    int r;
    // Reset state
    step(3);
    check("rst_valid", int'(aer_valid), 0);
    check("rst_addr", int'(aer_addr), 0);
    check("rst_time", int'(aer_time), 0);
    check("rst_drop", int'(drop_cnt), 0);
    rst = 1'b1;
    aer_ready = 1'b1;
    step(2);

    // Immediate release: delay[2]=0 from reset
    c = cyc; push(2, c + 2);
    pulse_fire(8'h04);
    step(4);

    // Delayed release: delay[5]=3
    cfg(5, 3, 1'b1);
    pulse_fire(8'h20);
    step(3);
    do_tick(); step(4);
    do_tick(); step(4);
    c = cyc; tick = 1'b1; ts_model++; push(5, c + 2); step(1); tick = 1'b0;
    step(4);

    // Round-robin under backpressure; first put the pointer on 0 via neuron 7
    c = cyc; push(7, c + 2);
    pulse_fire(8'h80);
    step(3);
    aer_ready = 1'b0;
    pulse_fire(8'h49);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("bp_valid", int'(aer_valid), 1);
      check("bp_addr_hold", int'(aer_addr), 0);
    end
    r = cyc;
    push(0, r); push(3, r + 1); push(6, r + 2);
    aer_ready = 1'b1;
    step(4);
    c = cyc; push(7, c + 2); push(1, c + 3);
    pulse_fire(8'h82);
    step(4);

    // Drop: second fire while slot 1 counts
    cfg(1, 4, 1'b1);
    pulse_fire(8'h02);
    step(1);
    pulse_fire(8'h02);
    check("drop_single", int'(drop_cnt), 1);
    check("drop_single_w2", int'(drop_cnt2), 1);
    do_tick(); step(2);
    do_tick(); step(2);
    do_tick(); step(2);
    c = cyc; tick = 1'b1; ts_model++; push(1, c + 2); step(1); tick = 1'b0;
    step(4);

    // Several drops in one cycle, and saturation of the 2-bit counter
    cfg(3, 2, 1'b1);
    cfg(6, 2, 1'b1);
    pulse_fire(8'h4A);
    pulse_fire(8'h4A);
    check("drop_multi", int'(drop_cnt), 4);
    check("drop_sat_w2", int'(drop_cnt2), 3);
    pulse_fire(8'h02);
    check("drop_five", int'(drop_cnt), 5);
    check("drop_sat_hold_w2", int'(drop_cnt2), 3);
    do_tick(); step(3);
    c = cyc; tick = 1'b1; ts_model++; push(3, c + 2); push(6, c + 3); step(1); tick = 1'b0;
    step(4);
    do_tick(); step(3);
    c = cyc; tick = 1'b1; ts_model++; push(1, c + 2); step(1); tick = 1'b0;
    step(4);

    // Disable while busy: no event, no drop; later fire ignored
    cfg(4, 3, 1'b1);
    pulse_fire(8'h10);
    do_tick(); step(2);
    cfg(4, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_tick(); step(2);
    end
    pulse_fire(8'h10);
    for (int i = 0; i < 4; i++) begin
      do_tick(); step(2);
    end
    check("dis_valid", int'(aer_valid), 0);
    check("dis_drop", int'(drop_cnt), 5);

    // Reset mid-handshake with three slots busy
    aer_ready = 1'b0;
    cfg(0, 5, 1'b1);
    cfg(2, 5, 1'b1);
    pulse_fire(8'h25);
    pulse_fire(8'h80);
    step(2);
    check("pre_rst_valid", int'(aer_valid), 1);
    check("pre_rst_addr", int'(aer_addr), 7);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("arst_valid", int'(aer_valid), 0);
    check("arst_addr", int'(aer_addr), 0);
    check("arst_time", int'(aer_time), 0);
    check("arst_drop", int'(drop_cnt), 0);
    check("arst_drop_w2", int'(drop_cnt2), 0);
    ts_model = 0;
    step(2);
    rst = 1'b1;
    aer_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_tick(); step(2);
    end
    check("post_rst_valid", int'(aer_valid), 0);
    // en[4] back to 1 and delay[4] back to 0 after reset
    c = cyc; push(4, c + 2);
    pulse_fire(8'h10);
    step(5);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
